// File: rtl/ram_loader_ctrl_if.sv
// Host-to-loader byte stream: valid/ready handshake carrying one DATA_W byte.
interface ram_loader_ctrl_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ram_loader_ctrl.sv
// Program RAM loader: streams bytes into the RAM programming port, checks the host
// checksum, reads the region back and holds the CPU off the RAM while busy.
module ram_loader_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] len_m1,
    ram_loader_ctrl_if.slave  stream,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_w_en,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_w_en,
    output logic              ram_prog_mode,
    output logic [ADDR_W-1:0] ram_prog_addr,
    output logic [DATA_W-1:0] ram_w_data,
    input  logic [DATA_W-1:0] ram_r_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {IDLE, LOAD, CHK, VERIFY} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q, base_q, rem_q, cnt_q;
    logic [DATA_W-1:0] sum_q, rb_sum_q, rb_sum_d, checksum_q;
    logic [ADDR_W-1:0] prog_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic              prog_mode_q, busy_q, hold_q, done_q;
    logic [1:0]        err_q;
    logic              addr_act_q, rd_valid_q;
    logic              accept;

    assign stream.in_ready = (state_q == LOAD) || (state_q == CHK);
    assign accept          = stream.in_valid && stream.in_ready;
    assign rb_sum_d        = rb_sum_q + ram_r_data;

    assign ram_address   = hold_q ? ptr_q : cpu_addr;
    assign ram_w_en      = cpu_w_en & ~hold_q;
    assign ram_prog_mode = prog_mode_q;
    assign ram_prog_addr = prog_addr_q;
    assign ram_w_data    = w_data_q;
    assign cpu_hold      = hold_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign checksum      = checksum_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            base_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            rb_sum_q    <= '0;
            checksum_q  <= '0;
            prog_addr_q <= '0;
            w_data_q    <= '0;
            prog_mode_q <= 1'b0;
            busy_q      <= 1'b0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= '0;
            addr_act_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            prog_mode_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ptr_q    <= start_addr;
                        base_q   <= start_addr;
                        rem_q    <= len_m1;
                        cnt_q    <= len_m1;
                        sum_q    <= '0;
                        rb_sum_q <= '0;
                        done_q   <= 1'b0;
                        err_q    <= '0;
                        busy_q   <= 1'b1;
                        hold_q   <= 1'b1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        prog_mode_q <= 1'b1;
                        prog_addr_q <= ptr_q;
                        w_data_q    <= stream.in_data;
                        sum_q       <= sum_q + stream.in_data;
                        ptr_q       <= ptr_q + ADDR_W'(1);
                        if (rem_q == '0) state_q <= CHK;
                        else             rem_q   <= rem_q - ADDR_W'(1);
                    end
                end
                CHK: begin
                    if (accept) begin
                        err_q[0]   <= (stream.in_data != sum_q);
                        checksum_q <= sum_q;
                        ptr_q      <= base_q;
                        addr_act_q <= 1'b1;
                        rd_valid_q <= 1'b0;
                        state_q    <= VERIFY;
                    end
                end
                VERIFY: begin
                    // Address phase runs N cycles; read data trails by one, so the
                    // final cycle (address phase over) folds in the last byte.
                    rd_valid_q <= addr_act_q;
                    if (addr_act_q) begin
                        ptr_q <= ptr_q + ADDR_W'(1);
                        if (cnt_q == '0) addr_act_q <= 1'b0;
                        else             cnt_q      <= cnt_q - ADDR_W'(1);
                    end
                    if (rd_valid_q) rb_sum_q <= rb_sum_d;
                    if (!addr_act_q) begin
                        err_q[1] <= (rb_sum_d != sum_q);
                        done_q   <= ~err_q[0] & (rb_sum_d == sum_q);
                        busy_q   <= 1'b0;
                        hold_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader_ctrl.sv
// Randomized bench for ram_loader_ctrl: behavioural RAM plus a transaction-level
// reference of load addresses, sums, flags and cycle timing.
module tb_ram_loader_ctrl;

    logic       clk, rst, start;
    logic [3:0] start_addr, len_m1, cpu_addr;
    logic       cpu_w_en;
    logic [3:0] ram_address, ram_prog_addr;
    logic       ram_w_en, ram_prog_mode;
    logic [7:0] ram_w_data, ram_r_data, checksum;
    logic       cpu_hold, busy, done;
    logic [1:0] err;

    ram_loader_ctrl_if #(.DATA_W(8)) s_if ();

    ram_loader_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len_m1(len_m1),
        .stream(s_if.slave), .cpu_addr(cpu_addr), .cpu_w_en(cpu_w_en),
        .ram_address(ram_address), .ram_w_en(ram_w_en), .ram_prog_mode(ram_prog_mode),
        .ram_prog_addr(ram_prog_addr), .ram_w_data(ram_w_data), .ram_r_data(ram_r_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 16x8 RAM: programming port has priority, CPU writes store a marker.
    logic [7:0] ram_mem [16];
    logic [7:0] ref_mem [16];
    logic [7:0] data_b  [16];

    always @(posedge clk) begin
        if (ram_prog_mode)  ram_mem[ram_prog_addr] <= ram_w_data;
        else if (ram_w_en)  ram_mem[ram_address]   <= 8'hEE;
        ram_r_data <= ram_mem[ram_address];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // vmode: 0 valid always, 1 valid every other cycle, 2 random valid.
    task automatic run_load(input logic [3:0] sa, input logic [3:0] lm1, input logic [7:0] chkb,
                            input int vmode, input int abort_at, input bit poke);
        int         n = int'(lm1) + 1;
        int         acc = 0;
        int         cyc = 0;
        bit         last_acc = 1'b0;
        bit         chk_done = 1'b0;
        bit         v;
        logic [3:0] a, last_addr;
        logic [7:0] last_data, s;
        logic       e0;
        s = 8'h00;
        last_addr = 4'h0;
        last_data = 8'h00;

        start = 1'b1; start_addr = sa; len_m1 = lm1; s_if.in_valid = 1'b0;
        tick();
        start = 1'b0; start_addr = ~sa; len_m1 = ~lm1;
        check("busy_after_start", busy, 1);
        check("hold_after_start", cpu_hold, 1);

        while (!chk_done) begin
            check("prog_mode", ram_prog_mode, last_acc);
            if (last_acc) begin
                check("prog_addr", ram_prog_addr, last_addr);
                check("w_data", ram_w_data, last_data);
            end
            if (abort_at != 0 && acc == abort_at) begin
                rst = 1'b0; s_if.in_valid = 1'b0;
                tick();
                rst = 1'b1;
                check("abort_busy", busy, 0);
                check("abort_hold", cpu_hold, 0);
                check("abort_prog", ram_prog_mode, 0);
                check("abort_ready", s_if.in_ready, 0);
                check("abort_done", done, 0);
                check("abort_err", err, 0);
                check("abort_sum", checksum, 0);
                return;
            end
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            s_if.in_valid = v;
            s_if.in_data  = (acc < n) ? data_b[acc] : chkb;
            cpu_addr = 4'($urandom);
            cpu_w_en = 1'($urandom);
            start    = poke && (cyc == 1);
            #1;
            a = sa + 4'(acc);
            check("in_ready_load", s_if.in_ready, 1);
            check("ram_addr_held", ram_address, a);
            check("ram_w_en_held", ram_w_en, 0);
            tick();
            start = 1'b0;
            last_acc = v && (acc < n);
            if (v) begin
                if (acc < n) begin
                    last_addr = a;
                    last_data = data_b[acc];
                    s += data_b[acc];
                    ref_mem[a] = data_b[acc];
                end else begin
                    chk_done = 1'b1;
                end
                acc++;
            end
            cyc++;
            if (cyc > 400) begin
                check("load_timeout", 0, 1);
                return;
            end
        end

        s_if.in_valid = 1'b0;
        cpu_w_en = 1'b0;
        check("prog_after_chk", ram_prog_mode, 0);
        for (int j = 0; j <= n; j++) begin
            check("busy_verify", busy, 1);
            check("ready_verify", s_if.in_ready, 0);
            if (j < n) check("verify_addr", ram_address, 4'(sa + 4'(j)));
            tick();
        end
        e0 = (chkb != s);
        check("busy_end", busy, 0);
        check("hold_end", cpu_hold, 0);
        check("checksum", checksum, s);
        check("err", err, {1'b0, e0});
        check("done", done, !e0);

        cpu_addr = 4'($urandom); cpu_w_en = 1'b1;
        #1;
        check("cpu_addr_pass", ram_address, cpu_addr);
        check("cpu_wen_pass", ram_w_en, 1);
        cpu_w_en = 1'b0;
        #1;
        check("cpu_wen_low", ram_w_en, 0);
    endtask

    task automatic check_mem();
        for (int k = 0; k < 16; k++) check($sformatf("mem[%0d]", k), ram_mem[k], ref_mem[k]);
    endtask

    initial begin
        logic [7:0] s;
        logic [3:0] sa, lm;
        for (int k = 0; k < 16; k++) begin
            ram_mem[k] = 8'h00;
            ref_mem[k] = 8'h00;
            data_b[k]  = 8'h00;
        end
        rst = 1'b0; start = 1'b0; start_addr = '0; len_m1 = '0;
        cpu_addr = '0; cpu_w_en = 1'b0; s_if.in_data = '0; s_if.in_valid = 1'b0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_checksum", checksum, 0);
        check("rst_ready", s_if.in_ready, 0);
        check("rst_prog", ram_prog_mode, 0);
        check("rst_prog_addr", ram_prog_addr, 0);
        check("rst_w_data", ram_w_data, 0);
        rst = 1'b1;
        tick();

        data_b[0] = 8'h01; data_b[1] = 8'h02; data_b[2] = 8'h03; data_b[3] = 8'h04;
        run_load(4'd0, 4'd3, 8'h0A, 0, 0, 1'b0);
        check_mem();

        data_b[0] = 8'hFF; data_b[1] = 8'h80; data_b[2] = 8'h80; data_b[3] = 8'h01;
        run_load(4'd14, 4'd3, 8'h00, 0, 0, 1'b0);
        check_mem();
        run_load(4'd14, 4'd3, 8'h55, 2, 0, 1'b0);
        check_mem();

        for (int k = 0; k < 16; k++) data_b[k] = 8'h10;
        run_load(4'($urandom), 4'd15, 8'h00, 1, 0, 1'b0);
        check_mem();

        data_b[0] = 8'hA1; data_b[1] = 8'hB2; data_b[2] = 8'hC3; data_b[3] = 8'hD4;
        run_load(4'd5, 4'd3, 8'h00, 0, 2, 1'b0);
        tick();
        check_mem();

        for (int t = 0; t < 8; t++) begin
            sa = 4'($urandom);
            lm = (t == 0) ? 4'd7 : 4'($urandom);
            s = 8'h00;
            for (int k = 0; k < 16; k++) begin
                data_b[k] = 8'($urandom);
                if (k <= int'(lm)) s += data_b[k];
            end
            if (t == 0) sa = 4'd12;
            run_load(sa, lm, ($urandom_range(0, 3) == 0) ? ~s : s, (t == 0) ? 2 : t % 3, 0, t < 3);
            check_mem();
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
